// File: rtl/pc_redirect.sv
// Fetch PC register with control-transfer redirect, misaligned-target trap,
// post-redirect flush window and conditional-branch statistics counters.
module pc_redirect #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [6:0]  ex_opcode,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] rs1_data,
  input  logic        valid_branch,
  output logic [31:0] pc,
  output logic        redirect,
  output logic        flush,
  output logic        misalign_err,
  output logic [31:0] br_count,
  output logic [31:0] br_taken_count,
  output logic        state_dbg
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] FLUSH_N   = 3'(FLUSH_CYCLES);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Handshake: there is none; an EX instruction is consumed in the single
  // cycle it is presented with ex_valid while the block is in RUN.
  state_t      state, state_nxt;
  logic [2:0]  flush_cnt, flush_cnt_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] target;
  logic        is_branch, is_jal, is_jalr;
  logic        take, misaligned, br_resolve;

  assign state_dbg = state;

  always_comb begin
    is_branch     = (ex_opcode == OP_BRANCH);
    is_jal        = (ex_opcode == OP_JAL);
    is_jalr       = (ex_opcode == OP_JALR);
    take          = ex_valid & (state == RUN) &
                    ((is_branch & valid_branch) | is_jal | is_jalr);
    target        = is_jalr ? ((rs1_data + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
    misaligned    = |target[1:0];
    redirect      = take & rst_n;
    br_resolve    = ex_valid & (state == RUN) & is_branch & ~stall;

    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    pc_nxt        = stall ? pc : pc + 32'd4;

    if (take) begin
      // Redirect wins over stall; a misaligned target traps instead.
      state_nxt     = FLUSH;
      flush_cnt_nxt = FLUSH_N;
      pc_nxt        = misaligned ? TRAP_VEC : target;
    end else if (state == FLUSH) begin
      flush_cnt_nxt = flush_cnt - 3'd1;
      if (flush_cnt <= 3'd1) begin
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      state          <= RUN;
      flush_cnt      <= 3'd0;
      flush          <= 1'b0;
      misalign_err   <= 1'b0;
      br_count       <= 32'd0;
      br_taken_count <= 32'd0;
    end else begin
      pc           <= pc_nxt;
      state        <= state_nxt;
      flush_cnt    <= flush_cnt_nxt;
      flush        <= (state_nxt == FLUSH);
      misalign_err <= take & misaligned;
      if (br_resolve) begin
        br_count <= br_count + 32'd1;
        if (valid_branch) begin
          br_taken_count <= br_taken_count + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect.sv
// Directed bench for pc_redirect: a cycle-level reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_pc_redirect;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
  localparam int          FC        = 2;
  localparam logic [6:0]  OP_BR     = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_ALU    = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic [6:0]  ex_opcode = OP_ALU;
  logic [31:0] ex_pc = 32'd0;
  logic [31:0] ex_imm = 32'd0;
  logic [31:0] rs1_data = 32'd0;
  logic        valid_branch = 1'b0;
  logic [31:0] pc;
  logic        redirect;
  logic        flush;
  logic        misalign_err;
  logic [31:0] br_count;
  logic [31:0] br_taken_count;
  logic        state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic check_en = 1'b1;

  // Reference model: flush window as a plain "cycles remaining" integer.
  logic [31:0] m_pc = RESET_PC;
  int          m_left = 0;
  logic        m_mis = 1'b0;
  logic [31:0] m_brc = 32'd0;
  logic [31:0] m_btk = 32'd0;

  pc_redirect #(
    .RESET_PC(RESET_PC),
    .TRAP_VEC(TRAP_VEC),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .ex_valid(ex_valid),
    .ex_opcode(ex_opcode),
    .ex_pc(ex_pc),
    .ex_imm(ex_imm),
    .rs1_data(rs1_data),
    .valid_branch(valid_branch),
    .pc(pc),
    .redirect(redirect),
    .flush(flush),
    .misalign_err(misalign_err),
    .br_count(br_count),
    .br_taken_count(br_taken_count),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_target();
    if (ex_opcode == OP_JALR) return (rs1_data + ex_imm) & 32'hFFFF_FFFE;
    return ex_pc + ex_imm;
  endfunction

  function automatic logic m_take();
    return rst_n && (m_left == 0) && ex_valid &&
           ((ex_opcode == OP_BR && valid_branch) || ex_opcode == OP_JAL || ex_opcode == OP_JALR);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RESET_PC; m_left = 0; m_mis = 1'b0; m_brc = 32'd0; m_btk = 32'd0;
    end else begin
      logic        t;
      logic [31:0] tgt;
      logic        in_run;
      t = m_take();
      tgt = m_target();
      in_run = (m_left == 0);
      if (in_run && ex_valid && ex_opcode == OP_BR && !stall) begin
        m_brc = m_brc + 32'd1;
        if (valid_branch) m_btk = m_btk + 32'd1;
      end
      if (t) begin
        m_mis  = (tgt % 4) != 0;
        m_pc   = m_mis ? TRAP_VEC : tgt;
        m_left = FC;
      end else begin
        m_mis = 1'b0;
        if (!stall) m_pc = m_pc + 32'd4;
        if (m_left > 0) m_left = m_left - 1;
      end
    end
  end

  // Compare just before each rising edge, after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (check_en) begin
      chk("m_pc", pc, m_pc);
      chk("m_redirect", {31'd0, redirect}, {31'd0, m_take()});
      chk("m_flush", {31'd0, flush}, {31'd0, m_left > 0});
      chk("m_state", {31'd0, state_dbg}, {31'd0, m_left > 0});
      chk("m_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
      chk("m_br_count", br_count, m_brc);
      chk("m_br_taken", br_taken_count, m_btk);
    end
  end

  task automatic cyc(input logic v, input logic [6:0] op, input logic [31:0] epc,
                     input logic [31:0] imm, input logic [31:0] rs1, input logic vb,
                     input logic st);
    @(negedge clk);
    ex_valid = v; ex_opcode = op; ex_pc = epc; ex_imm = imm;
    rs1_data = rs1; valid_branch = vb; stall = st;
    #1;
  endtask

  task automatic idle(input logic st);
    cyc(1'b0, OP_ALU, 32'd0, 32'd0, 32'd0, 1'b0, st);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    idle(1'b0);
    idle(1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("rst_brc", br_count, 32'd0);
    chk("rst_btk", br_taken_count, 32'd0);
    rst_n = 1'b1;
    chk("seq_pc0", pc, 32'h0);
    idle(1'b0); chk("seq_pc4", pc, 32'h4);
    idle(1'b0); chk("seq_pc8", pc, 32'h8);
    idle(1'b0); chk("seq_pcC", pc, 32'hC); chk("seq_flush", {31'd0, flush}, 32'd0);

    // Taken backward branch
    cyc(1'b1, OP_BR, 32'h40, 32'hFFFF_FFF0, 32'd0, 1'b1, 1'b0);
    chk("br_redirect", {31'd0, redirect}, 32'd1);
    idle(1'b0);
    chk("br_pc", pc, 32'h30); chk("br_flush1", {31'd0, flush}, 32'd1);
    chk("br_cnt", br_count, 32'd1); chk("br_tk", br_taken_count, 32'd1);
    idle(1'b0); chk("br_flush2", {31'd0, flush}, 32'd1); chk("br_pc2", pc, 32'h34);
    idle(1'b0); chk("br_flush3", {31'd0, flush}, 32'd0); chk("br_pc3", pc, 32'h38);

    // Misaligned JALR traps
    cyc(1'b1, OP_JALR, 32'h38, 32'h0, 32'h203, 1'b0, 1'b0);
    chk("jalr_redirect", {31'd0, redirect}, 32'd1);
    idle(1'b0);
    chk("jalr_pc", pc, 32'h100); chk("jalr_mis1", {31'd0, misalign_err}, 32'd1);
    chk("jalr_flush1", {31'd0, flush}, 32'd1);
    idle(1'b0);
    chk("jalr_mis2", {31'd0, misalign_err}, 32'd0); chk("jalr_flush2", {31'd0, flush}, 32'd1);
    idle(1'b0); chk("jalr_flush3", {31'd0, flush}, 32'd0); chk("jalr_pc3", pc, 32'h108);

    // Taken branch during FLUSH is ignored
    cyc(1'b1, OP_JAL, 32'h200, 32'h20, 32'd0, 1'b0, 1'b0);
    chk("jal_redirect", {31'd0, redirect}, 32'd1);
    cyc(1'b1, OP_BR, 32'h500, 32'h40, 32'd0, 1'b1, 1'b0);
    chk("fl_pc", pc, 32'h220); chk("fl_redirect", {31'd0, redirect}, 32'd0);
    cyc(1'b1, OP_BR, 32'h500, 32'h40, 32'd0, 1'b1, 1'b0);
    chk("fl_pc2", pc, 32'h224); chk("fl_redirect2", {31'd0, redirect}, 32'd0);
    idle(1'b0);
    chk("fl_pc3", pc, 32'h228); chk("fl_brc", br_count, 32'd1); chk("fl_btk", br_taken_count, 32'd1);

    // Stalled taken branch held three cycles redirects once
    cyc(1'b1, OP_BR, 32'h300, 32'h10, 32'd0, 1'b1, 1'b1);
    chk("st_redirect1", {31'd0, redirect}, 32'd1); chk("st_pc0", pc, 32'h22C);
    cyc(1'b1, OP_BR, 32'h300, 32'h10, 32'd0, 1'b1, 1'b1);
    chk("st_redirect2", {31'd0, redirect}, 32'd0); chk("st_pc1", pc, 32'h310);
    cyc(1'b1, OP_BR, 32'h300, 32'h10, 32'd0, 1'b1, 1'b1);
    chk("st_redirect3", {31'd0, redirect}, 32'd0); chk("st_pc2", pc, 32'h310);
    idle(1'b1);
    chk("st_pc3", pc, 32'h310); chk("st_flush", {31'd0, flush}, 32'd0); chk("st_brc", br_count, 32'd1);
    idle(1'b0); chk("st_pc4", pc, 32'h310);
    idle(1'b0); chk("st_pc5", pc, 32'h314);

    // Counter wrap from all-ones
    force dut.br_count = 32'hFFFF_FFFF;
    m_brc = 32'hFFFF_FFFF;
    #2 release dut.br_count;
    cyc(1'b1, OP_BR, 32'h400, 32'h8, 32'd0, 1'b0, 1'b0);
    chk("wrap_redirect", {31'd0, redirect}, 32'd0);
    idle(1'b0);
    chk("wrap_brc", br_count, 32'd0); chk("wrap_btk", br_taken_count, 32'd1);

    // Misaligned taken branch still counts as taken
    cyc(1'b1, OP_BR, 32'h10, 32'h2, 32'd0, 1'b1, 1'b0);
    chk("mbr_redirect", {31'd0, redirect}, 32'd1);
    idle(1'b0);
    chk("mbr_pc", pc, 32'h100); chk("mbr_mis", {31'd0, misalign_err}, 32'd1);
    chk("mbr_btk", br_taken_count, 32'd2); chk("mbr_brc", br_count, 32'd1);
    idle(1'b0);
    idle(1'b0);

    // Aligned JALR clears bit 0; invalid JAL does nothing
    cyc(1'b1, OP_JALR, 32'h0, 32'h3, 32'h1001, 1'b0, 1'b0);
    chk("jalr2_redirect", {31'd0, redirect}, 32'd1);
    idle(1'b0);
    chk("jalr2_pc", pc, 32'h1004); chk("jalr2_mis", {31'd0, misalign_err}, 32'd0);
    idle(1'b0);
    idle(1'b0);
    cyc(1'b0, OP_JAL, 32'h0, 32'h80, 32'd0, 1'b0, 1'b0);
    chk("inv_redirect", {31'd0, redirect}, 32'd0);

    // Reset in the middle of a flush
    cyc(1'b1, OP_JAL, 32'h40, 32'h40, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, OP_JAL, 32'h40, 32'h40, 32'd0, 1'b0, 1'b0);
    chk("rf_flush", {31'd0, flush}, 32'd1); chk("rf_pc", pc, 32'h80);
    rst_n = 1'b0;
    #3;
    chk("rf_rst_pc", pc, RESET_PC); chk("rf_rst_flush", {31'd0, flush}, 32'd0);
    chk("rf_rst_redirect", {31'd0, redirect}, 32'd0); chk("rf_rst_brc", br_count, 32'd0);
    idle(1'b0);
    rst_n = 1'b1;
    chk("rf_pc0", pc, RESET_PC);
    idle(1'b0);
    chk("rf_pc4", pc, RESET_PC + 32'd4); chk("rf_flush2", {31'd0, flush}, 32'd0);
    idle(1'b0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
